// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch controller
package stopwatch_pkg;

   typedef enum logic [1:0] {ANIM, RUN, PAUSE, OVF} state_t;
   typedef logic [3:0] bcd_t;

   localparam logic [2:0] A2_LAST = 3'd6;

   function automatic int bcd2_val(input bcd_t tens, input bcd_t ones);
      return int'(tens) * 10 + int'(ones);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button inputs and display outputs of the stopwatch controller
interface stopwatch_ctrl_if;
   import stopwatch_pkg::*;

   logic       start_stop;
   logic       clear;
   logic       mode_btn;
   logic       set_inc;
   bcd_t       sec_ones;
   bcd_t       sec_tens;
   bcd_t       min_ones;
   bcd_t       min_tens;
   bcd_t       pre_ones;
   bcd_t       pre_tens;
   logic [2:0] a2;
   logic       signal;
   logic       error_over_start;
   logic       error_changing;
   logic       error_over_start_time;
   logic       mood;

   modport master (
      output start_stop, clear, mode_btn, set_inc,
      input  sec_ones, sec_tens, min_ones, min_tens, pre_ones, pre_tens,
      input  a2, signal, error_over_start, error_changing, error_over_start_time, mood
   );

   modport slave (
      input  start_stop, clear, mode_btn, set_inc,
      output sec_ones, sec_tens, min_ones, min_tens, pre_ones, pre_tens,
      output a2, signal, error_over_start, error_changing, error_over_start_time, mood
   );

endinterface

// File: rtl/bcd_mmss_counter.sv
// rtl/bcd_mmss_counter.sv - BCD mm:ss counter that saturates at 59:59
module bcd_mmss_counter
   import stopwatch_pkg::*;
(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_inc,
   input  logic i_clr,
   output bcd_t o_sec_ones,
   output bcd_t o_sec_tens,
   output bcd_t o_min_ones,
   output bcd_t o_min_tens,
   output logic o_wrap
);

   bcd_t r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;

   assign o_wrap = (r_min_tens == 4'd5) && (r_min_ones == 4'd9) &&
                   (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset || i_clr) begin
         r_sec_ones <= '0;
         r_sec_tens <= '0;
         r_min_ones <= '0;
         r_min_tens <= '0;
      end else if (i_inc && !o_wrap) begin
         if (r_sec_ones != 4'd9) begin
            r_sec_ones <= r_sec_ones + 4'd1;
         end else begin
            r_sec_ones <= '0;
            if (r_sec_tens != 4'd5) begin
               r_sec_tens <= r_sec_tens + 4'd1;
            end else begin
               r_sec_tens <= '0;
               if (r_min_ones != 4'd9) begin
                  r_min_ones <= r_min_ones + 4'd1;
               end else begin
                  r_min_ones <= '0;
                  r_min_tens <= r_min_tens + 4'd1;
               end
            end
         end
      end
   end

   assign o_sec_ones = r_sec_ones;
   assign o_sec_tens = r_sec_tens;
   assign o_min_ones = r_min_ones;
   assign o_min_tens = r_min_tens;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch FSM, prescalers, preset counter and error timers
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV   = 50_000_000,
   parameter int ANIM_DIV   = 12_500_000,
   parameter int ERR_HOLD   = 100_000_000,
   parameter int PRESET_MAX = 99
)(
   input  logic i_clk,
   input  logic i_reset,
   stopwatch_ctrl_if.slave io
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam int EW = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
   localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_HOLD - 1);

   logic [1:0]    r_rst_sync;
   logic          w_rst_n;
   state_t        r_state, w_state_nxt;
   logic [TW-1:0] r_tick_cnt;
   logic [AW-1:0] r_anim_cnt;
   logic [EW-1:0] r_chg_cnt, r_time_cnt;
   logic [2:0]    r_a2;
   logic          r_signal, r_mood, r_err_over, r_err_chg, r_err_time;
   bcd_t          r_pre_ones, r_pre_tens;
   logic          w_tick, w_wrap, w_cnt_inc, w_tick_clr, w_to_anim, w_ovf_set, w_edit_err;
   logic          w_pre_req, w_pre_full;

   // Reset asserts immediately but releases synchronously to i_clk.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_tick     = (r_state == RUN) && (r_tick_cnt == TICK_LAST);
   assign w_pre_req  = r_mood && io.set_inc && !io.start_stop && !io.clear && (r_state != OVF);
   assign w_pre_full = bcd2_val(r_pre_tens, r_pre_ones) >= PRESET_MAX;

   bcd_mmss_counter u_mmss (
      .i_clk      (i_clk),
      .i_reset    (w_rst_n),
      .i_inc      (w_cnt_inc),
      .i_clr      (w_to_anim),
      .o_sec_ones (io.sec_ones),
      .o_sec_tens (io.sec_tens),
      .o_min_ones (io.min_ones),
      .o_min_tens (io.min_tens),
      .o_wrap     (w_wrap)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_inc   = 1'b0;
      w_tick_clr  = 1'b0;
      w_to_anim   = 1'b0;
      w_ovf_set   = 1'b0;
      w_edit_err  = 1'b0;
      unique case (r_state)
         ANIM: if (io.start_stop) begin
            w_state_nxt = RUN;
            w_tick_clr  = 1'b1;
         end
         RUN: begin
            if (w_tick && w_wrap) begin
               w_state_nxt = OVF;
               w_ovf_set   = 1'b1;
            end else begin
               w_cnt_inc = w_tick;
               if (io.start_stop)                              w_state_nxt = PAUSE;
               else if (io.clear || (io.set_inc && !r_mood))   w_edit_err  = 1'b1;
            end
         end
         PAUSE: begin
            if (io.start_stop) begin
               w_state_nxt = RUN;
            end else if (io.clear) begin
               w_state_nxt = ANIM;
               w_to_anim   = 1'b1;
            end
         end
         OVF: if (io.clear) begin
            w_state_nxt = ANIM;
            w_to_anim   = 1'b1;
         end
         default: w_state_nxt = ANIM;
      endcase
   end

   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= ANIM;
         r_signal   <= 1'b0;
         r_tick_cnt <= '0;
         r_anim_cnt <= '0;
         r_a2       <= 3'd0;
         r_mood     <= 1'b0;
         r_err_over <= 1'b0;
         r_pre_ones <= '0;
         r_pre_tens <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_signal <= (w_state_nxt != ANIM);
         if (w_tick_clr)            r_tick_cnt <= '0;
         else if (r_state == RUN)   r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
         if (w_to_anim) begin
            r_anim_cnt <= '0;
            r_a2       <= 3'd0;
         end else if (r_state == ANIM && !io.start_stop) begin
            if (r_anim_cnt == ANIM_LAST) begin
               r_anim_cnt <= '0;
               r_a2       <= (r_a2 == A2_LAST) ? 3'd0 : r_a2 + 3'd1;
            end else begin
               r_anim_cnt <= r_anim_cnt + 1'b1;
            end
         end
         if (io.mode_btn) r_mood <= !r_mood;
         if (w_ovf_set)      r_err_over <= 1'b1;
         else if (w_to_anim) r_err_over <= 1'b0;
         if (w_pre_req && !w_pre_full) begin
            if (r_pre_ones == 4'd9) begin
               r_pre_ones <= '0;
               r_pre_tens <= r_pre_tens + 4'd1;
            end else begin
               r_pre_ones <= r_pre_ones + 4'd1;
            end
         end
      end
   end

   // Re-triggering reloads the hold count; nothing else cancels a running pulse.
   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_err_chg  <= 1'b0;
         r_chg_cnt  <= '0;
         r_err_time <= 1'b0;
         r_time_cnt <= '0;
      end else begin
         if (w_edit_err) begin
            r_err_chg <= 1'b1;
            r_chg_cnt <= ERR_LAST;
         end else if (r_err_chg) begin
            if (r_chg_cnt == '0) r_err_chg <= 1'b0;
            else                 r_chg_cnt <= r_chg_cnt - 1'b1;
         end
         if (w_pre_req && w_pre_full) begin
            r_err_time <= 1'b1;
            r_time_cnt <= ERR_LAST;
         end else if (r_err_time) begin
            if (r_time_cnt == '0) r_err_time <= 1'b0;
            else                  r_time_cnt <= r_time_cnt - 1'b1;
         end
      end
   end

   assign io.pre_ones              = r_pre_ones;
   assign io.pre_tens              = r_pre_tens;
   assign io.a2                    = r_a2;
   assign io.signal                = r_signal;
   assign io.error_over_start      = r_err_over;
   assign io.error_changing        = r_err_chg;
   assign io.error_over_start_time = r_err_time;
   assign io.mood                  = r_mood;

endmodule
